// File: rtl/pc_fetch_decode.sv
// Instruction front end: holds the PC, fetches over a req/ack port and issues
// decoded ADDI/BNE to the register-file/ALU datapath under valid/ready.
//
// state | meaning
// FETCH | imem_req held high until imem_ack, word captured into inst
// ISSUE | decoded fields presented; pc advances on issue_valid & issue_ready
// HALT  | illegal encoding or misaligned taken branch; left only via reset
module pc_fetch_decode #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  input  logic                     EQ,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic [PC_WIDTH-1:0]      pc,
  output logic                     halted
);

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BNE  = 7'b1100011;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   inst;
  logic                    is_addi;
  logic                    is_bne;
  logic [DATA_WIDTH-1:0]   imm_i;
  logic [DATA_WIDTH-1:0]   imm_b;
  logic [PC_WIDTH-1:0]     pc_plus4;
  logic [PC_WIDTH-1:0]     br_target;
  logic [PC_WIDTH-1:0]     next_pc;
  logic                    take_branch;
  logic                    misaligned;

  function automatic logic is_legal(input logic [DATA_WIDTH-1:0] w);
    return ((w[6:0] == OP_ADDI) && (w[14:12] == F3_ADDI)) ||
           ((w[6:0] == OP_BNE) && (w[14:12] == F3_BNE));
  endfunction

  always_comb begin
    is_addi = (inst[6:0] == OP_ADDI) && (inst[14:12] == F3_ADDI);
    is_bne  = (inst[6:0] == OP_BNE) && (inst[14:12] == F3_BNE);
    imm_i   = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
    imm_b   = {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  end

  assign rs1       = ADDRESS_WIDTH'(inst[19:15]);
  assign rs2       = ADDRESS_WIDTH'(inst[24:20]);
  assign rd        = ADDRESS_WIDTH'(inst[11:7]);
  assign ImmOp     = is_bne ? imm_b : imm_i;
  assign ALUsrc    = is_bne;
  // Gated by ready so a stalled ADDI never writes more than once.
  assign RegWrite  = issue_valid & is_addi & issue_ready;
  assign imem_addr = pc;

  assign pc_plus4    = pc + PC_WIDTH'(4);
  assign br_target   = pc + PC_WIDTH'($signed(imm_b));
  assign take_branch = is_bne & ~EQ;
  assign next_pc     = take_branch ? br_target : pc_plus4;
  assign misaligned  = take_branch & br_target[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      inst        <= '0;
      halted      <= 1'b0;
      imem_req    <= 1'b0;
      issue_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          if (imem_req && imem_ack) begin
            inst        <= imem_rdata;
            imem_req    <= 1'b0;
            issue_valid <= is_legal(imem_rdata);
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!issue_valid) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (issue_ready) begin
            issue_valid <= 1'b0;
            if (misaligned) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          halted      <= 1'b1;
          imem_req    <= 1'b0;
          issue_valid <= 1'b0;
        end
        default: begin
          state       <= HALT;
          halted      <= 1'b1;
          imem_req    <= 1'b0;
          issue_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_decode.sv
// Directed bench for pc_fetch_decode: inputs driven and outputs sampled on the
// falling clock edge, expected values hand-computed from the instruction words.
module tb_pc_fetch_decode;

  localparam logic [31:0] W_ADDI1   = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] W_ADDI2   = 32'hFFF00113; // addi x2,x0,-1
  localparam logic [31:0] W_BNE_M8  = 32'hFE209CE3; // bne x1,x2,-8
  localparam logic [31:0] W_BNE_M4  = 32'hFE001EE3; // bne x0,x0,-4
  localparam logic [31:0] W_BNE_P2  = 32'h00001163; // bne x0,x0,+2
  localparam logic [31:0] W_ILLEGAL = 32'h00000033;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        issue_valid;
  logic        issue_ready;
  logic        EQ;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp;
  logic        RegWrite;
  logic        ALUsrc;
  logic [31:0] pc;
  logic        halted;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_fetch_decode dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .EQ(EQ),
    .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
    .pc(pc), .halted(halted)
  );

  // Zero-wait fetch + issue starting from a falling edge in FETCH; no checks.
  task automatic step_instr(input logic [31:0] w, input logic eq);
    imem_ack = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0; issue_ready = 1'b1; EQ = eq;
    @(negedge clk);
    issue_ready = 1'b0; EQ = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; issue_ready = 1'b0; EQ = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", issue_valid); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_checks++; if (RegWrite !== 1'b0 || ALUsrc !== 1'b0 || ImmOp !== 32'h0) begin
      n_fail++; $display("FAIL reset_ctrl got rw=%b src=%b imm=%h want 0", RegWrite, ALUsrc, ImmOp); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addi;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_fetch got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = W_ADDI1; issue_ready = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b want 1", issue_valid); end
    n_checks++; if (rd !== 5'd1 || rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_regs got rd=%0d rs1=%0d want 1/0", rd, rs1); end
    n_checks++; if (ImmOp !== 32'd5) begin n_fail++; $display("FAIL addi_imm got %h want 5", ImmOp); end
    n_checks++; if (ALUsrc !== 1'b0 || RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL addi_ctrl got src=%b rw=%b want 0/1", ALUsrc, RegWrite); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL addi_req_in_issue got %b want 0", imem_req); end
    @(negedge clk);
    issue_ready = 1'b0;
    n_checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL addi_next got addr=%h req=%b v=%b want 4/1/0", imem_addr, imem_req, issue_valid); end
  endtask

  task automatic test_stall;
    imem_ack = 1'b1; imem_rdata = W_ADDI2;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (issue_valid !== 1'b1 || RegWrite !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v=%b rw=%b want 1/0", i, issue_valid, RegWrite); end
      n_checks++; if (ImmOp !== 32'hFFFFFFFF || rd !== 5'd2) begin
        n_fail++; $display("FAIL stall_fields[%0d] got imm=%h rd=%0d want ffffffff/2", i, ImmOp, rd); end
      n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want 4", i, pc); end
      @(negedge clk);
    end
    issue_ready = 1'b1;
    #1;
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL stall_accept_rw got %b want 1", RegWrite); end
    @(negedge clk);
    issue_ready = 1'b0;
    n_checks++; if (pc !== 32'h8 || imem_addr !== 32'h8) begin
      n_fail++; $display("FAIL stall_pc_next got pc=%h addr=%h want 8", pc, imem_addr); end
  endtask

  task automatic test_bne;
    logic [31:0] want [2];
    want[0] = 32'h08; want[1] = 32'h14;
    for (int k = 0; k < 2; k++) begin
      step_instr(W_ADDI1, 1'b0);
      step_instr(W_ADDI1, 1'b0);
      n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL bne_setup_pc[%0d] got %h want 10", k, pc); end
      imem_ack = 1'b1; imem_rdata = W_BNE_M8;
      @(negedge clk);
      imem_ack = 1'b0; issue_ready = 1'b1; EQ = (k == 1);
      #1;
      n_checks++; if (issue_valid !== 1'b1 || ALUsrc !== 1'b1 || RegWrite !== 1'b0) begin
        n_fail++; $display("FAIL bne_ctrl[%0d] got v=%b src=%b rw=%b want 1/1/0", k, issue_valid, ALUsrc, RegWrite); end
      n_checks++; if (ImmOp !== 32'hFFFFFFF8 || rs1 !== 5'd1 || rs2 !== 5'd2) begin
        n_fail++; $display("FAIL bne_fields[%0d] got imm=%h rs1=%0d rs2=%0d want fffffff8/1/2", k, ImmOp, rs1, rs2); end
      @(negedge clk);
      issue_ready = 1'b0; EQ = 1'b0;
      n_checks++; if (imem_addr !== want[k] || imem_req !== 1'b1) begin
        n_fail++; $display("FAIL bne_target[%0d] got addr=%h req=%b want %h/1", k, imem_addr, imem_req, want[k]); end
    end
  endtask

  task automatic test_ack_wait;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14 || issue_valid !== 1'b0) begin
        n_fail++; $display("FAIL ackwait[%0d] got req=%b addr=%h v=%b want 1/14/0", i, imem_req, imem_addr, issue_valid); end
      @(negedge clk);
    end
    imem_ack = 1'b1; imem_rdata = W_ADDI1;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (issue_valid !== 1'b1 || rd !== 5'd1) begin
      n_fail++; $display("FAIL ackwait_issue got v=%b rd=%0d want 1/1", issue_valid, rd); end
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    n_checks++; if (pc !== 32'h18) begin n_fail++; $display("FAIL ackwait_pc got %h want 18", pc); end
  endtask

  task automatic test_illegal;
    logic saw_valid;
    saw_valid = 1'b0;
    imem_ack = 1'b1; imem_rdata = W_ILLEGAL; issue_ready = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 8 && halted !== 1'b1; i++) begin
      if (issue_valid === 1'b1) saw_valid = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL illegal_halt got %b want 1 within 8 cycles", halted); end
    n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_valid got 1 want never"); end
    imem_ack = 1'b1; imem_rdata = W_ADDI1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0 || issue_valid !== 1'b0 || RegWrite !== 1'b0 || halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_sticky[%0d] got req=%b v=%b rw=%b h=%b want 0/0/0/1", i, imem_req, issue_valid, RegWrite, halted); end
    end
    imem_ack = 1'b0; issue_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_reset got h=%b pc=%h req=%b want 0/0/0", halted, pc, imem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL halt_restart got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_misaligned;
    step_instr(W_BNE_M4, 1'b0);
    n_checks++; if (pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_back got %h want fffffffc", pc); end
    step_instr(W_ADDI1, 1'b0);
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_fwd got %h want 0", pc); end
    step_instr(W_BNE_P2, 1'b0);
    n_checks++; if (halted !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL misaligned got h=%b pc=%h req=%b want 1/0/0", halted, pc, imem_req); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_in_issue;
    step_instr(W_ADDI1, 1'b0);
    n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL rst_issue_setup got %h want 4", pc); end
    imem_ack = 1'b1; imem_rdata = W_ADDI2;
    @(negedge clk);
    imem_ack = 1'b0; issue_ready = 1'b1;
    #1;
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL rst_issue_pre got rw=%b want 1", RegWrite); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (RegWrite !== 1'b0 || issue_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin
      n_fail++; $display("FAIL rst_issue_drop got rw=%b v=%b req=%b pc=%h want 0/0/0/0", RegWrite, issue_valid, imem_req, pc); end
    @(posedge clk);
    #1;
    n_checks++; if (pc !== 32'h0 || imem_req !== 1'b0 || RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL rst_issue_hold got pc=%h req=%b rw=%b want 0/0/0", pc, imem_req, RegWrite); end
    @(negedge clk);
    rst_n = 1'b1; issue_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_issue_restart got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_stall();
    test_bne();
    test_ack_wait();
    test_illegal();
    test_wrap_misaligned();
    test_reset_in_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_decode.md
Name: pc_fetch_decode

Overview:
- Front end feeding the single-cycle register-file/ALU datapath.
- Holds the PC and fetches 32-bit instructions over a req/ack instruction-memory handshake.
- Decodes each instruction into register addresses, immediate and control, and presents them to the datapath under a valid/ready handshake.
- Consumes the datapath EQ flag to resolve BNE.
- Supported instructions: ADDI and BNE. Any other encoding halts the core.

Parameters:
- ADDRESS_WIDTH, 5, register-file address width.
- DATA_WIDTH, 32, instruction/immediate width.
- PC_WIDTH, 32, program counter width.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_WIDTH  byte address of fetch (= pc)
- imem_ack  in  1  rdata valid this cycle
- imem_rdata  in  DATA_WIDTH  instruction word
- issue_valid  out  1  decoded instruction presented to datapath
- issue_ready  in  1  datapath accepts this cycle
- EQ  in  1  datapath ALU equality flag, combinational, same cycle
- rs1, rs2, rd  out  ADDRESS_WIDTH  register addresses
- ImmOp  out  DATA_WIDTH  sign-extended immediate
- RegWrite  out  1  register write enable
- ALUsrc  out  1  1 = second ALU operand is RD2, 0 = ImmOp
- pc  out  PC_WIDTH  current PC
- halted  out  1  sticky stop flag

Behaviour:
- Reset (async assert, sync release): state=FETCH, pc=RESET_PC, instruction register=0, halted=0. All other outputs 0, including imem_req.
- First rising edge after release: imem_req=1, imem_addr=RESET_PC.
- FSM states: FETCH, ISSUE, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc, issue_valid=0, RegWrite=0.
  - On imem_ack, latch imem_rdata into the instruction register and go to ISSUE.
  - imem_req stays high every cycle until ack; addr is stable while waiting.
- ISSUE:
  - issue_valid=1 only for a legal instruction; outputs decoded from the instruction register and stable until accept.
  - Accept = issue_valid & issue_ready. RegWrite is gated with issue_ready, so the datapath writes exactly once per instruction.
  - On accept, update pc and go to FETCH.
- Decode:
  - rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7].
  - ADDI (opcode 0010011, funct3 000): ImmOp=sext(inst[31:20]), ALUsrc=0, RegWrite=1, next pc=pc+4.
  - BNE (opcode 1100011, funct3 001): ImmOp=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}), ALUsrc=1, RegWrite=0.
  - BNE resolution: EQ sampled in the accept cycle. EQ=0 -> next pc=pc+ImmOp, EQ=1 -> pc+4.
  - Other opcode/funct3: illegal. issue_valid=0, RegWrite=0, go to HALT.
- Arithmetic: pc updates are modulo 2^PC_WIDTH; wrap from 0xFFFFFFFC+4 gives 0.
- Misaligned branch: taken target with bit1=1 -> HALT instead of updating pc; pc keeps the BNE address.
- HALT: halted=1, imem_req=0, issue_valid=0, RegWrite=0. Exit only via reset.
- imem_ack outside FETCH is ignored. issue_ready outside ISSUE is ignored.
- Reset mid-fetch or mid-issue: outputs drop immediately on rst_n low; no write or PC update occurs from the aborted instruction.
- Throughput: minimum 2 cycles per instruction (1 fetch + 1 issue) with zero-wait ack and ready.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093), ack one cycle later, ready=1 -> imem_addr=0; next cycle issue_valid=1, rd=1, rs1=0, ImmOp=5, ALUsrc=0, RegWrite=1; then imem_addr=4.
- ADDI x2,x0,-1 (0xFFF00113) with issue_ready low 3 cycles -> outputs held, RegWrite=0 while stalled, ImmOp=0xFFFFFFFF, RegWrite=1 only in the accept cycle, pc 4->8.
- BNE x1,x2,-8 (0xFE209CE3) at pc=0x10: EQ=0 -> next imem_addr=0x08. Repeat with EQ=1 -> next imem_addr=0x14. ALUsrc=1 and RegWrite=0 in both cases.
- imem_ack withheld 4 cycles -> imem_req high and imem_addr constant throughout, no issue_valid; then normal issue.
- Illegal word 0x00000033 -> issue_valid never asserts, halted=1, imem_req=0 permanently. Pulse rst_n low mid-HALT -> halted=0, fetch restarts at RESET_PC.
- rst_n asserted during ISSUE with ready=1 on the same edge -> no write, pc=RESET_PC, imem_req=0 during reset.
